// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - control stage that captures an external signed multiplier's product into HI/LO
module mul_hilo_ctrl #(
   parameter int DATA_WIDTH    = 32,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   op_q,
   input  logic [DATA_WIDTH-1:0]   op_m,
   output logic [DATA_WIDTH-1:0]   mul_q,
   output logic [DATA_WIDTH-1:0]   mul_m,
   input  logic [2*DATA_WIDTH-1:0] mul_prod,
   input  logic                    hi_we,
   input  logic                    lo_we,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_WIDTH-1:0]   hi,
   output logic [DATA_WIDTH-1:0]   lo
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_SETTLE = 1'b1
   } state_t;

   localparam logic [3:0] L_SETTLE = 4'(SETTLE_CYCLES);

   state_t                  r_state;
   logic [3:0]              r_cnt;
   logic                    r_done;
   logic [DATA_WIDTH-1:0]   r_mul_q;
   logic [DATA_WIDTH-1:0]   r_mul_m;
   logic [DATA_WIDTH-1:0]   r_hi;
   logic [DATA_WIDTH-1:0]   r_lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_done  <= 1'b0;
         r_mul_q <= '0;
         r_mul_m <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // Direct writes land at the same edge a multiply is accepted; the capture later overwrites them.
               if (hi_we) r_hi <= wr_data;
               if (lo_we) r_lo <= wr_data;
               if (start) begin
                  r_mul_q <= op_q;
                  r_mul_m <= op_m;
                  r_cnt   <= L_SETTLE;
                  r_state <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (r_cnt != 4'd1) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_hi    <= mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
                  r_lo    <= mul_prod[DATA_WIDTH-1:0];
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign busy  = (r_state == S_SETTLE);
   assign done  = r_done;
   assign mul_q = r_mul_q;
   assign mul_m = r_mul_m;
   assign hi    = r_hi;
   assign lo    = r_lo;

endmodule
